fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing one FIFO write port among NUM_REQ producers (e.g. CPU store path, DMA, debug).
- Each producer uses a valid/ready handshake.
- The block grants one owner at a time, forwards that owner's data into the FIFO write port for a bounded burst, then rotates priority.
- Sits directly in front of the FIFO's wr_en/din/full interface.

Parameters:
- DATA_WIDTH, 8, width of each data word and of the FIFO din.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, max words written per grant before forced rotation (1..16).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester data valid
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- grant  output  NUM_REQ  one-hot current owner, registered; 0 when idle
- busy  output  1  high while in GRANT state
- fifo_full  input  1  FIFO full flag
- fifo_wr_en  output  1  FIFO write enable
- fifo_din  output  DATA_WIDTH  FIFO write data

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-low.
- Reset (reset==0 at posedge):
  - state=IDLE, grant=0, burst_cnt=0, last_owner=NUM_REQ-1 (requester 0 wins first).
  - Outputs: req_ready=0, fifo_wr_en=0, fifo_din=0, busy=0.
- Reset asserted mid-burst aborts at that edge. No write occurs in a cycle where reset==0.
- State IDLE:
  - If any req_valid, select the first valid requester scanning last_owner+1, last_owner+2, … modulo NUM_REQ.
  - Next edge: grant <= onehot(sel), owner <= sel, burst_cnt <= 0, state <= GRANT. Arbitration latency is 1 cycle.
  - No transfer occurs in IDLE.
- State GRANT (combinational outputs from registered owner):
  - req_ready[owner] = !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[owner] && !fifo_full.
  - fifo_din = req_data[owner slice] when fifo_wr_en, else 0.
  - A transfer occurs on any cycle with fifo_wr_en=1, and is counted in burst_cnt.
- Release rules, evaluated at each edge in GRANT:
  - (a) Transfer occurs and burst_cnt==MAX_BURST-1 -> last_owner<=owner, grant<=0, state<=IDLE.
  - (b) req_valid[owner]==0 -> release identically (no transfer that cycle).
  - Otherwise stay in GRANT, burst_cnt += transfer.
- After release the block always passes through IDLE for one cycle. Max throughput is MAX_BURST words per MAX_BURST+1 cycles.
- fifo_full while granted: stall and hold the grant; burst_cnt is unchanged; no timeout.
  - If the owner drops valid during the stall, rule (b) applies.
- Other requesters' valid changes during a grant have no effect until the next IDLE.
- Simultaneous requests in IDLE are resolved strictly by rotation from last_owner. No starvation: each valid requester is served within NUM_REQ grants.
- burst_cnt width: $clog2(MAX_BURST+1) bits; it never wraps.

Optional Feature:
- Macro: FIFO_WR_ARBITER_STATS_EN.
- With the macro defined:
  - Adds input stat_sel [$clog2(NUM_REQ)-1:0] and output stat_count [15:0].
  - One 16-bit saturating transfer counter per requester, incremented on each transfer by that owner and held at 16'hFFFF.
  - All counters are cleared by reset.
  - stat_count = counter[stat_sel], combinational.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then req_valid=4'b0001, data 8'hA0..A5 -> grant=0001 one cycle later; 4 writes A0..A3, IDLE 1 cycle, regrant; A4, A5 written; fifo_wr_en never high during IDLE.
- req_valid=4'b1111 held, fifo_full=0 -> grant order 0,1,2,3,0, each grant 4 consecutive writes, 1 idle cycle between.
- Owner 2 granted, fifo_full=1 for 5 cycles after its 2nd write -> fifo_wr_en=0, req_ready=0 for those 5 cycles; grant held; then 2 more writes and release.
- Owner 1 drops req_valid after 1 write -> grant clears next edge; last_owner=1; requester 2 (valid) is granted next, ahead of 0.
- reset=0 pulsed during the 3rd word of a burst -> grant=0, fifo_wr_en=0 next cycle; after reset, requester 0 wins over a simultaneous request from 3.
- With FIFO_WR_ARBITER_STATS_EN: 10 words from requester 3 -> stat_sel=3 reads 10, others read 0; forcing 70000 transfers reads 16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// among NUM_REQ valid/ready producers. A grant lasts until MAX_BURST words
// have been written or the owner drops valid. After that the block spends
// one cycle in IDLE and re-arbitrates, starting just after the last owner.
//
// Handshake: a word moves from requester i into the FIFO on a cycle where
// req_valid[i] && req_ready[i]. That cycle is exactly a cycle with
// fifo_wr_en=1. req_ready follows !fifo_full for the current owner only,
// and it does not depend on that owner's valid.
//
// Optional build macro FIFO_WR_ARBITER_STATS_EN adds per-requester 16-bit
// saturating transfer counters. They are read through stat_sel/stat_count.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
`ifdef FIFO_WR_ARBITER_STATS_EN
  input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
  output logic [15:0]                   stat_count,
`endif
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_GRANT = 1'b1;
  localparam logic [OW:0]   NREQ_W   = (OW+1)'(NUM_REQ);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  logic [0:0]            r_state;
  logic [OW-1:0]         r_owner;
  logic [OW-1:0]         r_last_owner;
  logic [CW-1:0]         r_burst_cnt;
  logic [NUM_REQ-1:0]    r_grant;

  logic                  w_sel_found;
  logic [OW-1:0]         w_sel;
  logic [OW:0]           w_idx;
  logic                  w_own_valid;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic [NUM_REQ-1:0]    w_own_onehot;
  logic                  w_active;
  logic                  w_xfer;

  // Rotating priority scan: the first valid requester after r_last_owner.
  // The loop runs from the lowest priority to the highest, so the last hit wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel       = '0;
    w_idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = {1'b0, r_last_owner} + (OW+1)'(k);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (req_valid[w_idx[OW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel       = w_idx[OW-1:0];
      end
    end
  end

  // Select the registered owner's valid, data slice and one-hot ready mask.
  always_comb begin
    w_own_valid  = 1'b0;
    w_own_data   = '0;
    w_own_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_own_valid     = req_valid[i];
        w_own_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_own_onehot[i] = 1'b1;
      end
    end
  end

  // While reset is asserted, neither a write nor a ready is allowed.
  assign w_active   = (r_state == ST_GRANT) && reset;
  assign w_xfer     = w_active && w_own_valid && !fifo_full;
  assign req_ready  = (w_active && !fifo_full) ? w_own_onehot : '0;
  assign fifo_wr_en = w_xfer;
  assign fifo_din   = w_xfer ? w_own_data : '0;
  assign grant      = r_grant;
  assign busy       = (r_state == ST_GRANT);

  // Arbitration FSM: IDLE picks an owner, and GRANT streams until the burst limit or a valid drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
      r_grant      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_found) begin
            r_state     <= ST_GRANT;
            r_owner     <= w_sel;
            r_grant     <= NUM_REQ'(1) << w_sel;
            r_burst_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (!w_own_valid || (w_xfer && (r_burst_cnt == LAST_CNT))) begin
            r_state      <= ST_IDLE;
            r_last_owner <= r_owner;
            r_grant      <= '0;
            r_burst_cnt  <= '0;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] r_stat_cnt [NUM_REQ];

  // Per-owner transfer counters. Each one stops at 16'hFFFF.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat_cnt[i] <= '0;
    end else if (w_xfer && (r_stat_cnt[r_owner] != 16'hFFFF)) begin
      r_stat_cnt[r_owner] <= r_stat_cnt[r_owner] + 16'd1;
    end
  end

  // Counter readback. A select beyond NUM_REQ reads as zero.
  always_comb begin
    stat_count = '0;
    if (int'(stat_sel) < NUM_REQ) stat_count = r_stat_cnt[stat_sel];
  end
`endif

endmodule
